// File: rtl/dfa_enum_pkg.sv
// dfa_enum_pkg: shared types and limits for the DFA word enumerator.
// Holds the FSM state enum, the MAX_LEN ceiling and the mismatch counter width.
package dfa_enum_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } enum_state_t;

  localparam int MAX_LEN_LIMIT = 16;
  localparam int MM_CNT_W      = 32;

endpackage

// File: rtl/word_counter.sv
// word_counter: shortlex (len, word) generator for the DFA word enumerator.
// Ports: clk, reset_n, clear, next -> len, word, last (current word is final one).
module word_counter
  import dfa_enum_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               next,
  output logic [LEN_W-1:0]   len,
  output logic [MAX_LEN:0]   word,
  output logic               last
);

  localparam int WW = MAX_LEN + 1;

  logic [WW-1:0] mask;
  logic          full;

  // mask = 2^len - 1; one extra word bit keeps this exact at len=MAX_LEN
  assign mask = ~({WW{1'b1}} << len);
  assign full = (word == mask);
  assign last = full && (len == LEN_W'(MAX_LEN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len  <= '0;
      word <= '0;
    end else if (clear) begin
      len  <= '0;
      word <= '0;
    end else if (next) begin
      if (!full) begin
        word <= word + WW'(1);
      end else if (!last) begin
        len  <= len + LEN_W'(1);
        word <= '0;
      end
    end
  end

endmodule

// File: rtl/dfa_word_enumerator.sv
// dfa_word_enumerator: drives every binary word of length 0..MAX_LEN, shortlex,
// into two automata (reset pulse, bits LSB first, sample strobe) and captures
// the first word on which the comparator reports a mismatch.
// Ports: clk, reset_n, start, mismatch -> dut_reset, dut_in, sample, busy,
// done, found, cex_word, cex_len; mismatch_cnt when
// DFA_ENUM_MISMATCH_COUNT_EN is defined (otherwise first mismatch ends run).
module dfa_word_enumerator
  import dfa_enum_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mismatch,
  output logic                dut_reset,
  output logic                dut_in,
  output logic                sample,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [MAX_LEN-1:0]  cex_word,
  output logic [LEN_W-1:0]    cex_len
`ifdef DFA_ENUM_MISMATCH_COUNT_EN
  ,
  output logic [MM_CNT_W-1:0] mismatch_cnt
`endif
);

  enum_state_t      state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len;
  logic [MAX_LEN:0] word;
  logic             last;
  logic             cnt_next;
  logic             cnt_clear;
  logic             hit;

  word_counter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .next    (cnt_next),
    .len     (len),
    .word    (word),
    .last    (last)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_next  = 1'b0;
    cnt_clear = 1'b0;
    hit       = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_d   = RST;
        end
      end
      RST: begin
        idx_d = '0;
        if (len == '0) state_d = CHECK;
        else           state_d = SHIFT;
      end
      SHIFT: begin
        idx_d = idx_q + LEN_W'(1);
        if (idx_q == len - LEN_W'(1))
          state_d = CHECK;
      end
      CHECK: begin
        hit = mismatch && !found;
`ifdef DFA_ENUM_MISMATCH_COUNT_EN
        cnt_next = 1'b1;
        state_d  = last ? DONE : RST;
`else
        if (mismatch) begin
          state_d = DONE;
        end else begin
          cnt_next = 1'b1;
          state_d  = last ? DONE : RST;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so each strobe lines
  // up with the cycle its state occupies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      dut_reset <= 1'b0;
      dut_in    <= 1'b0;
      sample    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dut_reset <= (state_d == RST);
      dut_in    <= (state_d == SHIFT) ? word[idx_d] : 1'b0;
      sample    <= (state_d == CHECK);
      busy      <= (state_d == RST) || (state_d == SHIFT) ||
                   (state_d == CHECK);
      done      <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found    <= 1'b0;
      cex_word <= '0;
      cex_len  <= '0;
    end else if (cnt_clear) begin
      found    <= 1'b0;
      cex_word <= '0;
      cex_len  <= '0;
    end else if (hit) begin
      found    <= 1'b1;
      cex_word <= word[MAX_LEN-1:0];
      cex_len  <= len;
    end
  end

`ifdef DFA_ENUM_MISMATCH_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch_cnt <= '0;
    end else if (cnt_clear) begin
      mismatch_cnt <= '0;
    end else if ((state_q == CHECK) && mismatch &&
                 (mismatch_cnt != '1)) begin
      mismatch_cnt <= mismatch_cnt + MM_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dfa_word_enumerator.sv
// tb_dfa_word_enumerator: directed + randomized checks of the enumerator,
// with a bench-side pair of "automata" that disagree on a chosen word set.
module tb_dfa_word_enumerator;

  localparam int ML = 3;
  localparam int LW = $clog2(ML + 1);
  localparam int NW = 1 << ML;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mismatch;
  logic          dut_reset, dut_in, sample, busy, done, found;
  logic [ML-1:0] cex_word;
  logic [LW-1:0] cex_len;
`ifdef DFA_ENUM_MISMATCH_COUNT_EN
  logic [31:0]   mismatch_cnt;
`endif

  dfa_word_enumerator #(.MAX_LEN(ML)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mismatch  (mismatch),
    .dut_reset (dut_reset),
    .dut_in    (dut_in),
    .sample    (sample),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .cex_word  (cex_word),
    .cex_len   (cex_len)
`ifdef DFA_ENUM_MISMATCH_COUNT_EN
    ,
    .mismatch_cnt (mismatch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  bit bad [0:ML][0:NW-1];

  int cur_len = 0;
  int cur_word = 0;
  logic prev_rst = 1'b0;
  int prot_err = 0;
  int log_len[$];
  int log_word[$];

  // Bench automata: they disagree exactly on the words marked in bad[][].
  always_comb begin
    mismatch = 1'b0;
    if (sample && cur_len <= ML && cur_word < NW)
      mismatch = bad[cur_len][cur_word];
  end

  // Rebuild each driven word from the serial stream it sees.
  always @(posedge clk) begin
    if (dut_reset && prev_rst) prot_err <= prot_err + 1;
    prev_rst <= dut_reset;
    if (dut_reset) begin
      cur_len  <= 0;
      cur_word <= 0;
    end else if (sample) begin
      log_len.push_back(cur_len);
      log_word.push_back(cur_word);
    end else if (busy) begin
      if (cur_len < 16) cur_word <= cur_word | (int'(dut_in) << cur_len);
      cur_len <= cur_len + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bad(input int mode);
    for (int l = 0; l <= ML; l++)
      for (int w = 0; w < NW; w++) begin
        case (mode)
          0: bad[l][w] = 1'b0;
          1: bad[l][w] = (l == 1 && w == 1);
          2: bad[l][w] = (w < (1 << l));
          default: bad[l][w] = ($urandom_range(0, 9) == 0);
        endcase
      end
  endtask

  task automatic run(input bit mid_start, input string nm);
    int e_len[$];
    int e_word[$];
    int cost, cnt, cyc, p0, mid_at;
    bit e_found, stop;
    int e_cl, e_cw;
    cost = 0; cnt = 0; e_found = 0; stop = 0; e_cl = 0; e_cw = 0;
    for (int l = 0; l <= ML; l++)
      for (int w = 0; w < (1 << l); w++) begin
        if (!stop) begin
          e_len.push_back(l);
          e_word.push_back(w);
          cost += l + 2;
          if (bad[l][w]) begin
            cnt++;
            if (!e_found) begin
              e_found = 1; e_cl = l; e_cw = w;
`ifndef DFA_ENUM_MISMATCH_COUNT_EN
              stop = 1;
`endif
            end
          end
        end
      end
    log_len.delete();
    log_word.delete();
    p0 = prot_err;
    mid_at = $urandom_range(3, 15);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({nm, "_busy_c1"}, busy, 1);
    chk({nm, "_rst_c1"}, dut_reset, 1);
    chk({nm, "_clr_c1"}, {found, cex_word, cex_len}, 0);
    cyc = 0;
    while (!done && cyc < 4000) begin
      start = mid_start && (cyc == mid_at);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, "_done_cycle"}, cyc + 1, cost + 1);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_found"}, found, e_found);
    chk({nm, "_cex_len"}, cex_len, e_cl);
    chk({nm, "_cex_word"}, cex_word, e_cw);
    chk({nm, "_nsamples"}, log_len.size(), e_len.size());
    for (int i = 0; i < e_len.size() && i < log_len.size(); i++)
      chk({nm, "_word"}, {32'(log_len[i]), 32'(log_word[i])},
          {32'(e_len[i]), 32'(e_word[i])});
    chk({nm, "_protocol"}, prot_err - p0, 0);
`ifdef DFA_ENUM_MISMATCH_COUNT_EN
    chk({nm, "_mm_cnt"}, mismatch_cnt, cnt);
`endif
    @(negedge clk);
    chk({nm, "_done_held"}, {done, sample, dut_reset}, 3'b100);
  endtask

  initial begin
    int to;
    #12;
    chk("reset_outs", {dut_reset, dut_in, sample, busy, done, found,
                       cex_word, cex_len}, 0);
    @(negedge clk) reset_n = 1'b1;

    set_bad(0);
    run(1'b0, "none");
    set_bad(1);
    run(1'b0, "single");
    set_bad(2);
    run(1'b0, "all");
    run(1'b1, "all_again");
    set_bad(1);
    run(1'b1, "single_midstart");
    run(1'b0, "single_repeat");
    for (int k = 0; k < 4; k++) begin
      set_bad(3);
      run(k[0], "random");
    end

    set_bad(0);
    log_len.delete();
    log_word.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    to = 0;
    while (!(log_len.size() == 3 && busy && !dut_reset && !sample) &&
           to < 200) begin
      @(negedge clk);
      to++;
    end
    chk("shift_wait_timeout", to >= 200, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("midrun_reset_outs", {dut_reset, dut_in, sample, busy, done,
                              found, cex_word, cex_len}, 0);
    @(negedge clk) reset_n = 1'b1;
    run(1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dfa_word_enumerator.md
# dfa_word_enumerator

Stimulus source for the automaton equivalence harness. Enumerates every binary word of length 0..MAX_LEN in shortlex order and drives each one serially into the automata under test: a reset pulse, then the word's bits, then a one-cycle sample strobe. The block samples the comparator's mismatch flag on each strobe and captures the first counterexample word. It is the transmitting end of the same `reset` / `in` interface that the equivalence checker consumes.

## Interface
Parameters:
- MAX_LEN, 8: longest word enumerated, 1..16.
- LEN_W, $clog2(MAX_LEN+1): width of length fields.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: pulse that begins enumeration; ignored while busy.
- mismatch, input, 1: comparator result (out1 != out2); sampled only when sample=1.
- dut_reset, output, 1: registered, active-high reset to the automata.
- dut_in, output, 1: registered serial symbol to the automata.
- sample, output, 1: registered strobe; automata outputs reflect the complete current word.
- busy, output, 1: enumeration in progress.
- done, output, 1: enumeration finished; held until the next start.
- found, output, 1: at least one mismatch seen.
- cex_word, output, MAX_LEN: first counterexample; bit i is the i-th symbol driven; bits at and above cex_len are 0.
- cex_len, output, LEN_W: length of the first counterexample.

## Operation
- FSM states: IDLE, RST, SHIFT, CHECK, DONE.
- IDLE: all outputs 0. start=1 -> clear found, cex_*, len=0, word=0 -> RST.
- RST: dut_reset=1 for exactly one cycle. If len=0 -> CHECK, else idx=0 -> SHIFT.
- SHIFT: dut_in=word[idx], one symbol per cycle, bit 0 first. Leaves to CHECK after idx=len-1.
- CHECK: sample=1 and dut_in=0. If mismatch=1 and found=0, capture cex_word=word and cex_len=len, and set found.
- CHECK advance rule:
  - word < 2^len-1: word+1 -> RST.
  - Otherwise, if len < MAX_LEN: len+1, word=0 -> RST.
  - Otherwise -> DONE.
- DONE: done=1, busy=0. start=1 -> restart as from IDLE.
- Word order: word ascending within each length; lengths ascending.
- Total words: 2^(MAX_LEN+1)-1.
- Word counter is MAX_LEN+1 bits wide, so the increment never wraps.
- busy=1 in RST, SHIFT and CHECK.

## Timing
- Reset values: state=IDLE; every output 0, including cex_word and cex_len.
- Reset mid-run: all enumeration is abandoned, with no partial result retained.
- Cost per word: len+2 cycles (RST, len×SHIFT, CHECK).
- Full run: sum over L=0..MAX_LEN of 2^L·(L+2) cycles.
- start sampled at edge 0: RST occupies cycle 1.
- dut_in changes only on posedge, so the automata see each symbol at the following edge.
- mismatch is combinational from the automata outputs and must be stable during CHECK.
- Simultaneous start and CHECK: start is ignored.
- Mismatch outside CHECK: ignored.

## Configuration
- DFA_ENUM_MISMATCH_COUNT_EN defined:
  - Adds output mismatch_cnt [31:0], which counts every CHECK with mismatch=1, saturates at 2^32-1, and clears on start.
  - Enumeration always runs to completion.
- Undefined:
  - The port is absent.
  - The first mismatch in CHECK sends the FSM straight to DONE (found=1, done=1).

## Structure
- Package dfa_enum_pkg: enum_state_t (IDLE, RST, SHIFT, CHECK, DONE, 3-bit encoding), MAX_LEN_LIMIT=16, and the mismatch counter width constant.
- Sub-module word_counter: holds len and word, and provides the advance/last-word logic. It has a `next` strobe, a `clear` input, and outputs `len`, `word` and `last`.
- Top-level: FSM, idx counter, capture registers and output registers.

## Test plan
- MAX_LEN=3, mismatch tied 0, one start pulse -> 15 sample strobes; done rises at cycle 65; found=0; the dut_in sequence for len=2 is 00,10,01,11 (bit 0 first).
- MAX_LEN=3, mismatch=1 only on the CHECK of len=1, word=1 -> found=1, cex_len=1, cex_word=3'b001.
  - Macro undefined: done one cycle after that CHECK.
  - Macro defined: run completes and mismatch_cnt=1.
- MAX_LEN=3, mismatch tied 1 -> cex_len=0, cex_word=0. Macro defined: mismatch_cnt=15 at done.
- reset_n low during the SHIFT of a len=2 word -> all outputs 0 immediately; after release, start restarts from len=0 and busy=1 the next cycle.
- start pulsed again mid-run (ignored) and again after done -> second run is identical, with found and cex cleared at restart.
- Protocol check on every run: dut_reset high exactly 1 cycle per word, and the number of SHIFT cycles equals len before each sample.
